// File: rtl/ste_snd_dma_ctrl.sv
// STE DMA-sound frame controller: frame registers, word address counter and FIFO refill sequencing.
// Optional frame-end interrupt pulse and its enables are built in when SND_DMA_SINT_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for play & SREQ
//  REQ   | fetch request held until the arbiter grants (mack)
//  LOAD  | SLOAD_N held low for SLOAD_W cycles
//  CHK   | frame-end compare, loop reload or stop
module ste_snd_dma_ctrl #(
    parameter int ADDR_W  = 22,
    parameter int SLOAD_W = 4
) (
    input  logic              clk32,
    input  logic              rst,
    input  logic              CS,
    input  logic              RW,
    input  logic [5:0]        A,
    input  logic [15:0]       DIN,
    output logic [15:0]       DOUT,
    input  logic              SREQ,
    output logic              mreq,
    input  logic              mack,
    output logic [ADDR_W-2:0] maddr,
    output logic              SLOAD_N,
    output logic              playing,
    output logic              sint
);

    localparam int CW = ADDR_W - 1;
    localparam int HW = CW - 15;
    localparam int TW = (SLOAD_W > 2) ? $clog2(SLOAD_W) : 1;

    typedef enum logic [1:0] {IDLE, REQ, LOAD, CHK} state_t;

    state_t        state, state_n;
    logic          cs_d, wr;
    logic          play, play_n, loop, loop_n;
    logic          sie_loop, sie_once, en_loop_w, en_once_w;
    logic [CW-1:0] frame_start, start_n, frame_end, end_n;
    logic [CW-1:0] end_shadow, shadow_n, counter, counter_n;
    logic          mreq_n, sload_n_n, sint_n, reload;
    logic [CW-1:0] maddr_n;
    logic [TW-1:0] timer, timer_n;
    logic          unused_din;

    assign wr         = CS & ~RW & ~cs_d;
    assign playing    = play;
    assign unused_din = ^DIN[15:8];

`ifdef SND_DMA_SINT_EN
    assign en_loop_w = DIN[3];
    assign en_once_w = DIN[2];

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            sie_loop <= 1'b1;
            sie_once <= 1'b1;
        end else if (wr && A == 6'h00) begin
            sie_loop <= DIN[3];
            sie_once <= DIN[2];
        end
    end
`else
    assign en_loop_w = 1'b0;
    assign en_once_w = 1'b0;
    assign sie_loop  = 1'b0;
    assign sie_once  = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        mreq_n    = mreq;
        maddr_n   = maddr;
        sload_n_n = SLOAD_N;
        timer_n   = timer;
        counter_n = counter;
        shadow_n  = end_shadow;
        play_n    = play;
        loop_n    = loop;
        start_n   = frame_start;
        end_n     = frame_end;
        sint_n    = 1'b0;
        reload    = 1'b0;

        case (state)
            IDLE: begin
                if (play && SREQ) begin
                    state_n = REQ;
                    mreq_n  = 1'b1;
                    maddr_n = counter;
                end
            end
            REQ: begin
                if (mack) begin
                    mreq_n    = 1'b0;
                    sload_n_n = 1'b0;
                    counter_n = counter + CW'(1);
                    timer_n   = TW'(SLOAD_W - 1);
                    state_n   = LOAD;
                end else if (!play) begin
                    mreq_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (timer == '0) begin
                    sload_n_n = 1'b1;
                    state_n   = CHK;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            CHK: begin
                state_n = IDLE;
                if (counter >= end_shadow) begin
                    sint_n = loop ? sie_loop : sie_once;
                    if (loop) begin
                        reload    = 1'b1;
                        counter_n = frame_start;
                        shadow_n  = frame_end;
                        if (frame_start >= frame_end)
                            play_n = 1'b0;
                    end else begin
                        play_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // CPU ctrl write overrides play/loop; a reload coinciding with play=0 is dropped
        if (wr) begin
            case (A)
                6'h00: begin
                    play_n = DIN[0];
                    loop_n = DIN[1];
                    if (reload && !DIN[0]) begin
                        counter_n = counter;
                        shadow_n  = end_shadow;
                    end
                    if (DIN[0] && !play) begin
                        counter_n = frame_start;
                        shadow_n  = frame_end;
                        if (frame_start >= frame_end) begin
                            play_n = 1'b0;
                            sint_n = DIN[1] ? en_loop_w : en_once_w;
                        end
                    end
                end
                6'h01: start_n[CW-1:15] = DIN[HW-1:0];
                6'h02: start_n[14:7]    = DIN[7:0];
                6'h03: start_n[6:0]     = DIN[7:1];
                6'h07: end_n[CW-1:15]   = DIN[HW-1:0];
                6'h08: end_n[14:7]      = DIN[7:0];
                6'h09: end_n[6:0]       = DIN[7:1];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cs_d        <= 1'b0;
            play        <= 1'b0;
            loop        <= 1'b0;
            frame_start <= '0;
            frame_end   <= '0;
            end_shadow  <= '0;
            counter     <= '0;
            mreq        <= 1'b0;
            maddr       <= '0;
            SLOAD_N     <= 1'b1;
            timer       <= '0;
            sint        <= 1'b0;
        end else begin
            state       <= state_n;
            cs_d        <= CS;
            play        <= play_n;
            loop        <= loop_n;
            frame_start <= start_n;
            frame_end   <= end_n;
            end_shadow  <= shadow_n;
            counter     <= counter_n;
            mreq        <= mreq_n;
            maddr       <= maddr_n;
            SLOAD_N     <= sload_n_n;
            timer       <= timer_n;
            sint        <= sint_n;
        end
    end

    // Byte-address register view: hi = [CW-1:15], mid = [14:7], lo = [6:0] plus a zero bit 0
    always_comb begin
        DOUT = '0;
        if (CS && RW) begin
            case (A)
                6'h00: DOUT = {12'h000, sie_loop, sie_once, loop, play};
                6'h01: DOUT = 16'(frame_start[CW-1:15]);
                6'h02: DOUT = {8'h00, frame_start[14:7]};
                6'h03: DOUT = {8'h00, frame_start[6:0], 1'b0};
                6'h04: DOUT = 16'(counter[CW-1:15]);
                6'h05: DOUT = {8'h00, counter[14:7]};
                6'h06: DOUT = {8'h00, counter[6:0], 1'b0};
                6'h07: DOUT = 16'(frame_end[CW-1:15]);
                6'h08: DOUT = {8'h00, frame_end[14:7]};
                6'h09: DOUT = {8'h00, frame_end[6:0], 1'b0};
                default: DOUT = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ste_snd_dma_ctrl.sv
// Directed bench for ste_snd_dma_ctrl: frame play, loop reload, deferred start, abort, empty frame, reset.
module tb_ste_snd_dma_ctrl;

    localparam int SLOAD_W = 4;
`ifdef SND_DMA_SINT_EN
    localparam logic SINT_ON = 1'b1;
`else
    localparam logic SINT_ON = 1'b0;
`endif

    logic        clk32 = 1'b0;
    logic        rst, CS, RW, SREQ, mack;
    logic [5:0]  A;
    logic [15:0] DIN, DOUT;
    logic        mreq, SLOAD_N, playing, sint;
    logic [20:0] maddr;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rdata;
    logic [15:0] ctrl_en;

    ste_snd_dma_ctrl #(.ADDR_W(22), .SLOAD_W(SLOAD_W)) dut (
        .clk32(clk32), .rst(rst), .CS(CS), .RW(RW), .A(A), .DIN(DIN), .DOUT(DOUT),
        .SREQ(SREQ), .mreq(mreq), .mack(mack), .maddr(maddr), .SLOAD_N(SLOAD_N),
        .playing(playing), .sint(sint)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        CS = 1'b1; RW = 1'b0; A = a; DIN = d;
        tick();
        CS = 1'b0; RW = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [5:0] a, output logic [15:0] d);
        CS = 1'b1; RW = 1'b1; A = a;
        #1;
        d = DOUT;
        CS = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input logic [23:0] b);
        logic [15:0] d;
        rd(6'h04, d); check({tag, "_hi"},  d, {8'h00, b[23:16]});
        rd(6'h05, d); check({tag, "_mid"}, d, {8'h00, b[15:8]});
        rd(6'h06, d); check({tag, "_lo"},  d, {8'h00, b[7:0]});
    endtask

    task automatic wait_mreq();
        int n;
        n = 0;
        while (mreq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("mreq_wait", mreq, 1);
    endtask

    // Grant 2 cycles after mreq, then measure the SLOAD_N low width
    task automatic fetch(input logic [20:0] exp);
        int n;
        wait_mreq();
        check("fetch_maddr", maddr, exp);
        tick();
        mack = 1'b1;
        tick();
        mack = 1'b0;
        check("fetch_mreq_drop", mreq, 0);
        n = 0;
        while (SLOAD_N === 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("fetch_sload_len", n, SLOAD_W);
    endtask

    initial begin
        ctrl_en = SINT_ON ? 16'h000C : 16'h0000;
        rst = 1'b1; CS = 1'b0; RW = 1'b1; A = '0; DIN = '0; SREQ = 1'b0; mack = 1'b0;
        repeat (2) @(posedge clk32);
        #1;
        check("rst_mreq", mreq, 0);
        check("rst_sload", SLOAD_N, 1);
        check("rst_maddr", maddr, 0);
        check("rst_sint", sint, 0);
        check("rst_playing", playing, 0);
        check("rst_dout_idle", DOUT, 0);
        rd(6'h00, rdata); check("rst_ctrl", rdata, ctrl_en);
        rst = 1'b0;
        tick();

        // single frame, no loop
        wr(6'h01, 16'h0001); wr(6'h02, 16'h0000); wr(6'h03, 16'h0000);
        wr(6'h07, 16'h0001); wr(6'h08, 16'h0000); wr(6'h09, 16'h0008);
        rd(6'h01, rdata); check("t1_start_hi", rdata, 16'h0001);
        rd(6'h09, rdata); check("t1_end_lo", rdata, 16'h0008);
        SREQ = 1'b1;
        wr(6'h00, 16'h000D);
        check("t1_playing", playing, 1);
        rd(6'h00, rdata); check("t1_ctrl", rdata, ctrl_en | 16'h0001);
        for (int i = 0; i < 4; i++) fetch(21'h08000 + 21'(i));
        tick();
        check("t1_sint", sint, SINT_ON);
        check("t1_stopped", playing, 0);
        tick();
        check("t1_sint_end", sint, 0);
        repeat (3) tick();
        check("t1_no_mreq", mreq, 0);
        check("t1_sload_idle", SLOAD_N, 1);
        chk_cnt("t1_cnt", 24'h010008);

        // looping frame
        wr(6'h00, 16'h000F);
        for (int i = 0; i < 4; i++) fetch(21'h08000 + 21'(i));
        tick();
        check("t2_sint", sint, SINT_ON);
        check("t2_playing", playing, 1);
        chk_cnt("t2_cnt", 24'h010000);
        fetch(21'h08000);

        // new start/end mid-frame, applied at the loop reload
        wr(6'h01, 16'h0002);
        wr(6'h07, 16'h0002);
        for (int i = 1; i < 4; i++) fetch(21'h08000 + 21'(i));
        tick();
        check("t3_sint", sint, SINT_ON);
        chk_cnt("t3_cnt", 24'h020000);
        fetch(21'h10000);

        // play cleared while REQ is pending
        wait_mreq();
        check("t4_maddr", maddr, 21'h10001);
        wr(6'h00, 16'h000E);
        check("t4_mreq_drop", mreq, 0);
        check("t4_playing", playing, 0);
        repeat (4) tick();
        check("t4_sload", SLOAD_N, 1);
        check("t4_no_mreq", mreq, 0);
        chk_cnt("t4_cnt", 24'h020002);

        // empty frame: start == end
        wr(6'h01, 16'h0003); wr(6'h07, 16'h0003); wr(6'h09, 16'h0000);
        CS = 1'b1; RW = 1'b0; A = 6'h00; DIN = 16'h000D;
        tick();
        check("t5_playing", playing, 0);
        check("t5_sint", sint, SINT_ON);
        CS = 1'b0; RW = 1'b1;
        tick();
        check("t5_sint_end", sint, 0);
        repeat (3) tick();
        check("t5_no_mreq", mreq, 0);
        chk_cnt("t5_cnt", 24'h030000);

        // reset in the middle of LOAD
        wr(6'h01, 16'h0001); wr(6'h07, 16'h0001); wr(6'h09, 16'h0008);
        wr(6'h00, 16'h000D);
        wait_mreq();
        tick();
        mack = 1'b1;
        tick();
        mack = 1'b0;
        check("t6_in_load", SLOAD_N, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_sload", SLOAD_N, 1);
        check("t6_mreq", mreq, 0);
        check("t6_playing", playing, 0);
        check("t6_maddr", maddr, 0);
        rd(6'h01, rdata); check("t6_start_hi", rdata, 0);
        rd(6'h09, rdata); check("t6_end_lo", rdata, 0);
        rd(6'h05, rdata); check("t6_cnt_mid", rdata, 0);
        rd(6'h00, rdata); check("t6_ctrl", rdata, ctrl_en);
        rst = 1'b0;
        repeat (4) tick();
        check("t6_idle_mreq", mreq, 0);
        check("t6_idle_sint", sint, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
